// File: rtl/seq_udiv.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Define SEQ_UDIV_EARLY_EXIT_EN to finish dividend < divisor in one cycle.
module seq_udiv #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state;
  state_t nxt;

  logic [CW-1:0] cnt;
  logic [N-1:0]  q;
  logic [N-1:0]  d;
  logic [N-1:0]  r;
  logic [N:0]    rs;
  logic [N-1:0]  t;
  logic          borrow;
  logic [N-1:0]  qn;
  logic [N-1:0]  rn;
  logic          last;
  logic          dz;
  logic          early;

`ifdef SEQ_UDIV_EARLY_EXIT_EN
  assign early = dividend < divisor;
`else
  assign early = 1'b0;
`endif

  assign dz = divisor == '0;
  assign last = cnt == CW'(N - 1);

  // R stays below D, so its shifted value fits N+1 bits; on no borrow
  // the difference is below D and its low N bits are exact.
  assign rs = {r, q[N-1]};
  assign borrow = rs < {1'b0, d};
  assign t = rs[N-1:0] - d;
  assign rn = borrow ? rs[N-1:0] : t;
  assign qn = {q[N-2:0], ~borrow};

  assign busy = state != IDLE;
  assign done = state == DONE;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (dz || early) begin
            nxt = DONE;
          end else begin
            nxt = CALC;
          end
        end
      end
      CALC: begin
        if (last) begin
          nxt = DONE;
        end
      end
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt         <= '0;
      q           <= '0;
      d           <= '0;
      r           <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            q           <= dividend;
            d           <= divisor;
            r           <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            if (dz) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else if (early) begin
              remainder <= dividend;
            end
          end
        end
        CALC: begin
          q   <= qn;
          r   <= rn;
          cnt <= cnt + CW'(1);
          if (last) begin
            quotient  <= qn;
            remainder <= rn;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/seq_udiv.md
Name: seq_udiv

Overview:
- Sequential unsigned restoring divider; the inverse-direction companion to the team's unsigned multiplier datapath.
- Takes an N-bit dividend and an N-bit divisor over a start/done handshake.
- Produces quotient and remainder at one quotient bit per clock.
- Used for normalisation and result checking alongside the multiplier, so the same operand width is shared.

Parameters:
- N, 8, operand width in bits for dividend, divisor, quotient and remainder (N >= 2).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- dividend  input  N  unsigned dividend; captured on an accepted start.
- divisor  input  N  unsigned divisor; captured on an accepted start.
- busy  output  1  high while a division is in progress (CALC or DONE).
- done  output  1  one-cycle pulse; results valid in that cycle.
- quotient  output  N  unsigned quotient.
- remainder  output  N  unsigned remainder.
- div_by_zero  output  1  set with done when captured divisor == 0.

Behaviour:
- Reset: one clock, synchronous active-low. rst_n low at a rising edge forces state IDLE and clears busy, done, quotient, remainder, div_by_zero, the iteration counter and internal registers to 0. Reset mid-operation abandons the division: no done pulse, outputs read 0.
- States: IDLE, CALC, DONE. The state register and counter (ceil(log2(N+1)) bits) are the only control state.
- IDLE:
  - start=1 at edge T captures dividend into the working quotient register Q and divisor into D, and clears the partial remainder R (N+1 bits).
  - Divisor==0: go to DONE.
  - Otherwise: go to CALC with count=0.
  - busy=0 in IDLE.
- CALC:
  - Each cycle: shift {R,Q} left by one. Trial-subtract T = R_shifted - {1'b0,D} at N+1 bits.
  - If T is non-negative (no borrow): R=T and Q[0]=1. Else keep R_shifted and set Q[0]=0.
  - count increments each cycle. After the N-th step (count==N-1) go to DONE.
  - busy=1.
- DONE:
  - done=1 for exactly this cycle; busy stays 1.
  - quotient=Q; remainder=R[N-1:0].
  - div_by_zero case: quotient all ones, remainder = captured dividend, div_by_zero=1.
  - Next cycle: IDLE.
- Latency: start sampled at edge T gives done high in cycle T+N+1 (normal) or T+1 (div by zero). Next start is accepted at the edge ending the DONE cycle at the earliest? No: start is accepted only in IDLE, so the earliest accept is the edge after DONE. Throughput is one division per N+2 cycles.
- Output holding: quotient, remainder and div_by_zero are registered at the DONE transition and hold until the next accepted start. At that point they clear to 0; div_by_zero clears on accept.
- start while busy: ignored. It is not queued, and an operand change during CALC has no effect.
- Arithmetic: all values unsigned; the final R is always < D. Invariant checked by the bench: quotient*divisor + remainder == dividend, and remainder < divisor (divisor != 0).
- Boundaries:
  - dividend=0 gives q=0, r=0.
  - divisor=1 gives q=dividend, r=0.
  - dividend=divisor gives q=1, r=0.
  - dividend < divisor gives q=0, r=dividend.

Optional Feature:
- Macro: SEQ_UDIV_EARLY_EXIT_EN.
- Defined: in IDLE, an accepted start with divisor != 0 and dividend < divisor goes straight to DONE. The result is quotient=0, remainder=dividend, with done in cycle T+1. All other cases are unchanged.
- Undefined: that case runs the full N CALC cycles and produces the same values at T+N+1.
- Result values are identical in both builds; only latency differs.

Test Plan:
- Reset: assert rst_n=0 mid-CALC (N=8, 200/7) -> next cycle busy=0, done=0, quotient=0, remainder=0; no done pulse afterwards.
- Normal: start with 200/7, N=8 at edge T -> done=1 only in cycle T+9, quotient=28, remainder=4, div_by_zero=0, busy high T+1..T+9.
- Extremes: 255/1 -> q=255, r=0. 255/255 -> q=1, r=0. 0/13 -> q=0, r=0. All at T+9.
- Divide by zero: 77/0 -> done at T+1, div_by_zero=1, quotient=8'hFF, remainder=77.
- Handshake: re-assert start with 100/3 during CALC of 200/7 -> ignored; result 28 r 4. Then start in IDLE with 100/3 -> 33 r 1, with outputs held between the two operations.
- Small dividend: 5/9 -> q=0, r=5. done at T+1 with SEQ_UDIV_EARLY_EXIT_EN defined; at T+9 without it.
- Random regression: 10k random pairs checked against the invariant, both macro builds.
